// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer with start/pause button, preset load and expiry alarm.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart from the last loaded preset on expiry.
module countdown_timer #(
    parameter int ALARM_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SW_nT,
    input  logic        tick,
    input  logic        button,
    input  logic        rstButton,
    input  logic        load,
    input  logic [23:0] loadBus,
    output logic [23:0] timeBus,
    output logic        running,
    output logic        alarm
);

    typedef enum logic [1:0] {IDLE, PAUSE, RUN, DONE} state_t;

    localparam logic [7:0] LP_ALARM = 8'(ALARM_CYCLES);

    state_t     r_state;
    logic [4:0] r_hr;
    logic [5:0] r_min;
    logic [5:0] r_sec;
    logic       r_btn_prev;
    logic       r_armed;
    logic       r_running;
    logic       r_alarm;
    logic [7:0] r_alarm_cnt;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [4:0] r_rl_hr;
    logic [5:0] r_rl_min;
    logic [5:0] r_rl_sec;
`endif

    logic [4:0] w_ld_hr;
    logic [5:0] w_ld_min;
    logic [5:0] w_ld_sec;
    logic       w_edge;
    logic       w_nonzero;
    logic       w_last;
    logic       w_unused_pad;

    assign w_ld_hr   = (loadBus[20:16] > 5'd23) ? 5'd23 : loadBus[20:16];
    assign w_ld_min  = (loadBus[13:8]  > 6'd59) ? 6'd59 : loadBus[13:8];
    assign w_ld_sec  = (loadBus[5:0]   > 6'd59) ? 6'd59 : loadBus[5:0];
    assign w_unused_pad = ^{loadBus[23:21], loadBus[15:14], loadBus[7:6]};

    // r_armed masks the first cycle after reset so a held button is not seen as an edge
    assign w_edge    = button & ~r_btn_prev & SW_nT & r_armed;
    assign w_nonzero = (r_hr != 5'd0) || (r_min != 6'd0) || (r_sec != 6'd0);
    assign w_last    = (r_hr == 5'd0) && (r_min == 6'd0) && (r_sec == 6'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_hr        <= '0;
            r_min       <= '0;
            r_sec       <= '0;
            r_btn_prev  <= 1'b0;
            r_armed     <= 1'b0;
            r_running   <= 1'b0;
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            r_rl_hr     <= '0;
            r_rl_min    <= '0;
            r_rl_sec    <= '0;
`endif
        end else begin
            r_btn_prev <= button;
            r_armed    <= 1'b1;
            if (r_alarm) begin
                if (r_alarm_cnt == 8'd1) r_alarm <= 1'b0;
                r_alarm_cnt <= r_alarm_cnt - 8'd1;
            end

            if (rstButton) begin
                r_state     <= IDLE;
                r_running   <= 1'b0;
                r_hr        <= '0;
                r_min       <= '0;
                r_sec       <= '0;
                r_alarm     <= 1'b0;
                r_alarm_cnt <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                r_rl_hr     <= '0;
                r_rl_min    <= '0;
                r_rl_sec    <= '0;
`endif
            end else if (load && r_state != RUN) begin
                r_state     <= IDLE;
                r_running   <= 1'b0;
                r_hr        <= w_ld_hr;
                r_min       <= w_ld_min;
                r_sec       <= w_ld_sec;
                r_alarm     <= 1'b0;
                r_alarm_cnt <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                r_rl_hr     <= w_ld_hr;
                r_rl_min    <= w_ld_min;
                r_rl_sec    <= w_ld_sec;
`endif
            end else if (w_edge) begin
                case (r_state)
                    IDLE: begin
                        if (w_nonzero) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                    RUN: begin
                        r_state   <= PAUSE;
                        r_running <= 1'b0;
                    end
                    PAUSE: begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end else if (tick && r_state == RUN) begin
                if (r_sec != 6'd0) begin
                    r_sec <= r_sec - 6'd1;
                end else if (r_min != 6'd0) begin
                    r_sec <= 6'd59;
                    r_min <= r_min - 6'd1;
                end else if (r_hr != 5'd0) begin
                    r_sec <= 6'd59;
                    r_min <= 6'd59;
                    r_hr  <= r_hr - 5'd1;
                end
                if (w_last) begin
                    r_alarm     <= 1'b1;
                    r_alarm_cnt <= LP_ALARM;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if ({r_rl_hr, r_rl_min, r_rl_sec} != 17'd0) begin
                        r_hr  <= r_rl_hr;
                        r_min <= r_rl_min;
                        r_sec <= r_rl_sec;
                    end else begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                    end
`else
                    r_state   <= DONE;
                    r_running <= 1'b0;
`endif
                end
            end
        end
    end

    assign timeBus = {3'b000, r_hr, 2'b00, r_min, 2'b00, r_sec};
    assign running = r_running;
    assign alarm   = r_alarm;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: vector table plus expiry, alarm and reset sequences.
`timescale 1ns/1ps
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        SW_nT = 1'b1;
    logic        tick = 1'b0;
    logic        button = 1'b0;
    logic        rstButton = 1'b0;
    logic        load = 1'b0;
    logic [23:0] loadBus = '0;
    logic [23:0] timeBus;
    logic        running;
    logic        alarm;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.ALARM_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .SW_nT(SW_nT), .tick(tick), .button(button),
        .rstButton(rstButton), .load(load), .loadBus(loadBus),
        .timeBus(timeBus), .running(running), .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [23:0] bus;
        logic        btn;
        logic        tk;
        logic        sw;
        logic        rb;
        logic [23:0] et;
        logic        er;
        logic        ea;
    } vec_t;

    vec_t v[30];

    function automatic vec_t mk(logic ld, logic [23:0] bus, logic btn, logic tk,
                                logic sw, logic rb, logic [23:0] et, logic er, logic ea);
        vec_t r;
        r.ld = ld; r.bus = bus; r.btn = btn; r.tk = tk; r.sw = sw; r.rb = rb;
        r.et = et; r.er = er; r.ea = ea;
        return r;
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [23:0] et, input logic er, input logic ea);
        chk({name, ".time"}, timeBus, et);
        chk({name, ".running"}, {23'd0, running}, {23'd0, er});
        chk({name, ".alarm"}, {23'd0, alarm}, {23'd0, ea});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        load = 0; button = 0; tick = 0; rstButton = 0; SW_nT = 1;
    endtask

    initial begin
        int n;
        //           ld  bus        btn tk sw rb  time       run alm
        v[0]  = mk(1, 24'h000102, 0, 0, 1, 0, 24'h000102, 0, 0);
        v[1]  = mk(0, 24'h0,      1, 0, 1, 0, 24'h000102, 1, 0);
        v[2]  = mk(0, 24'h0,      0, 1, 1, 0, 24'h000101, 1, 0);
        v[3]  = mk(0, 24'h0,      0, 1, 1, 0, 24'h000100, 1, 0);
        v[4]  = mk(0, 24'h0,      0, 1, 1, 0, 24'h00003B, 1, 0);
        v[5]  = mk(0, 24'h0,      1, 1, 1, 0, 24'h00003B, 0, 0);
        v[6]  = mk(0, 24'h0,      0, 1, 1, 0, 24'h00003B, 0, 0);
        v[7]  = mk(0, 24'h0,      0, 1, 1, 0, 24'h00003B, 0, 0);
        v[8]  = mk(0, 24'h0,      1, 0, 0, 0, 24'h00003B, 0, 0);
        v[9]  = mk(0, 24'h0,      0, 0, 1, 0, 24'h00003B, 0, 0);
        v[10] = mk(0, 24'h0,      1, 0, 1, 0, 24'h00003B, 1, 0);
        v[11] = mk(0, 24'h0,      0, 1, 1, 0, 24'h00003A, 1, 0);
        v[12] = mk(1, 24'h1F3F3F, 0, 0, 1, 0, 24'h00003A, 1, 0);
        v[13] = mk(0, 24'h0,      1, 0, 1, 0, 24'h00003A, 0, 0);
        v[14] = mk(1, 24'hFFFFFF, 0, 0, 1, 0, 24'h173B3B, 0, 0);
        v[15] = mk(0, 24'h0,      1, 0, 1, 0, 24'h173B3B, 1, 0);
        v[16] = mk(0, 24'h0,      0, 1, 1, 0, 24'h173B3A, 1, 0);
        v[17] = mk(0, 24'h0,      1, 0, 1, 0, 24'h173B3A, 0, 0);
        v[18] = mk(1, 24'h010000, 0, 0, 1, 0, 24'h010000, 0, 0);
        v[19] = mk(0, 24'h0,      1, 0, 1, 0, 24'h010000, 1, 0);
        v[20] = mk(0, 24'h0,      0, 1, 1, 0, 24'h003B3B, 1, 0);
        v[21] = mk(0, 24'h0,      1, 0, 1, 0, 24'h003B3B, 0, 0);
        v[22] = mk(0, 24'h0,      0, 0, 1, 0, 24'h003B3B, 0, 0);
        v[23] = mk(1, 24'h000005, 1, 0, 1, 0, 24'h000005, 0, 0);
        v[24] = mk(0, 24'h0,      0, 0, 1, 0, 24'h000005, 0, 0);
        v[25] = mk(0, 24'h0,      1, 0, 1, 0, 24'h000005, 1, 0);
        v[26] = mk(0, 24'h0,      0, 0, 1, 0, 24'h000005, 1, 0);
        v[27] = mk(1, 24'h000009, 1, 0, 1, 1, 24'h000000, 0, 0);
        v[28] = mk(0, 24'h0,      0, 0, 1, 0, 24'h000000, 0, 0);
        v[29] = mk(0, 24'h0,      1, 0, 1, 0, 24'h000000, 0, 0);

        idle_in();
        rst = 0;
        #12;
        chk_all("reset", 24'h0, 1'b0, 1'b0);
        step();
        rst = 1;
        step();
        chk_all("post_reset", 24'h0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            load = v[i].ld; loadBus = v[i].bus; button = v[i].btn;
            tick = v[i].tk; SW_nT = v[i].sw; rstButton = v[i].rb;
            step();
            chk_all($sformatf("vec%0d", i), v[i].et, v[i].er, v[i].ea);
        end

        // expiry and alarm length
        idle_in();
        rstButton = 1; step(); rstButton = 0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        load = 1; loadBus = 24'h000002; step(); load = 0;
        button = 1; step(); button = 0;
        tick = 1; step();
        chk_all("ar_tick1", 24'h000001, 1'b1, 1'b0);
        step(); tick = 0;
        chk_all("ar_expire", 24'h000002, 1'b1, 1'b1);
`else
        load = 1; loadBus = 24'h000001; step(); load = 0;
        button = 1; step(); button = 0;
        tick = 1; step(); tick = 0;
        chk_all("expire", 24'h000000, 1'b0, 1'b1);
`endif
        n = 1;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) tick = 1;
            step();
            tick = 0;
            if (alarm) n++;
        end
        chk("alarm_len", 24'(n), 24'd8);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        chk_all("ar_after", 24'h000001, 1'b1, 1'b0);
`else
        chk_all("done_hold", 24'h000000, 1'b0, 1'b0);
        button = 1; step(); button = 0;
        chk_all("done_to_idle", 24'h000000, 1'b0, 1'b0);
        step();
        button = 1; step(); button = 0;
        chk_all("idle_zero", 24'h000000, 1'b0, 1'b0);
`endif

        // async reset mid-alarm
        rstButton = 1; step(); rstButton = 0;
        load = 1; loadBus = 24'h000001; step(); load = 0;
        button = 1; step(); button = 0;
        tick = 1; step(); tick = 0;
        step(); step();
        chk("pre_rst.alarm", {23'd0, alarm}, 24'd1);
        #2 rst = 0;
        #1;
        chk_all("async_rst", 24'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1;
        load = 1; loadBus = 24'h000004; step(); load = 0;
        chk_all("reload_after_rst", 24'h000004, 1'b0, 1'b0);
        button = 1; step(); button = 0;
        chk_all("run_after_rst", 24'h000004, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter ALARM_CYCLES, default 8, giving the number of clk cycles alarm is held high after expiry (legal 1..255).
REQ-002 The block SHALL have port clk  input  1  the single system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port SW_nT  input  1  enable; while low, button edges are ignored.
REQ-005 The block SHALL have port tick  input  1  one-cycle pulse that qualifies each one-second decrement.
REQ-006 The block SHALL have port button  input  1  start/pause level, synchronous to clk; its rising edge is detected internally.
REQ-007 The block SHALL have port rstButton  input  1  synchronous clear of count, reload value and state.
REQ-008 The block SHALL have port load  input  1  strobe that captures loadBus.
REQ-009 The block SHALL have port loadBus  input  24  preset as {3'b0, hours[4:0], 2'b0, minutes[5:0], 2'b0, seconds[5:0]}.
REQ-010 The block SHALL have port timeBus  output  24  remaining time, packed as for loadBus, with zero pad bits.
REQ-011 The block SHALL have port running  output  1  high exactly while the state is RUN.
REQ-012 The block SHALL have port alarm  output  1  expiry indication.

Function
REQ-013 The FSM SHALL have the states IDLE, PAUSE, RUN and DONE, with all outputs registered.
REQ-014 Priority each cycle SHALL be: rstButton, then load, then button edge, then tick.
REQ-015 A button edge SHALL be button=1 this cycle with the registered button=0 from the prior cycle, and SHALL count only when SW_nT=1.
REQ-016 load in IDLE, PAUSE or DONE SHALL capture loadBus into the count and reload registers, go to IDLE and cancel alarm; load in RUN SHALL be ignored.
REQ-017 load SHALL clamp fields: seconds>59 -> 59, minutes>59 -> 59, hours>23 -> 23; pad bits of loadBus SHALL be ignored.
REQ-018 A button edge SHALL move IDLE->RUN if the count is nonzero (otherwise the state stays IDLE), RUN->PAUSE, PAUSE->RUN, and DONE->IDLE.
REQ-019 In RUN with tick=1 the count SHALL decrement once: sec>0 gives sec-1; sec=0,min>0 gives sec=59,min-1; sec=0,min=0,hr>0 gives sec=59,min=59,hr-1.
REQ-020 tick SHALL be ignored in IDLE, PAUSE and DONE, and on a cycle where a higher-priority event acts.
REQ-021 The decrement that produces 00:00:00 SHALL move the FSM to DONE in the same edge, and alarm SHALL be high for exactly ALARM_CYCLES cycles starting the following cycle.
REQ-022 timeBus SHALL reflect the count one clk after the edge that updated it; there SHALL be no combinational path from inputs to outputs.
REQ-023 In DONE timeBus SHALL remain 0 until load, rstButton or the next expiry-cycle event.
REQ-024 rstButton SHALL set count=0, reload=0, state=IDLE and alarm=0, overriding a simultaneous load or button edge.
REQ-025 A load in the same cycle as a button edge SHALL apply the load and discard the edge.

Reset
REQ-026 While rst=0 the outputs SHALL be: timeBus=0, running=0, alarm=0; state IDLE, reload=0, button history=0, independent of clk.
REQ-027 Reset deassertion SHALL take effect at the next clk edge, with no spurious button edge generated.
REQ-028 Reset asserted mid-RUN or mid-alarm SHALL abort immediately to reset values.

Configuration
REQ-029 When macro COUNTDOWN_AUTO_RELOAD_EN is defined, expiry SHALL load the reload value into the count and stay in RUN (running stays 1), alarm SHALL still pulse per REQ-021, and a reload value of 0 SHALL instead go to DONE.
REQ-030 When COUNTDOWN_AUTO_RELOAD_EN is undefined, expiry SHALL go to DONE per REQ-021, and the reload register MAY be omitted.

Verification
REQ-031 Load 00:01:02, button edge, then 3 ticks -> timeBus reads 00:00:59 after the third tick; running=1.
REQ-032 Load 01:00:00, run, 1 tick -> 00:59:59; load 00:00:01, run, 1 tick -> DONE with running=0 and alarm high for 8 cycles (macro undefined).
REQ-033 Load 1F:3F:3F raw fields -> timeBus=23:59:59; a load during RUN leaves the count unchanged.
REQ-034 RUN, button edge, 5 ticks -> count frozen; button edge, 1 tick -> decrement resumes; edges with SW_nT=0 change nothing.
REQ-035 rstButton together with load and button edge -> count 0, IDLE, alarm 0; rst pulled low mid-alarm -> all outputs 0 asynchronously.
REQ-036 With COUNTDOWN_AUTO_RELOAD_EN defined, load 00:00:02, run, 2 ticks -> timeBus=00:00:02, running=1, alarm pulses for 8 cycles.
